// File: rtl/maxpool_window_drain_pkg.sv
// Shared types and constants for the max-pool window drain block.
// Lane geometry, FSM encoding and the lane-slice helper live here.
package maxpool_window_drain_pkg;

    localparam int LANES      = 16;
    localparam int DW         = 32;
    localparam int LANE_W     = 4;
    localparam int POOL_LEN_W = 4;
    localparam int POOL_WIN_W = 16;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_CAPTURE
    } state_t;

    // Pick lane k out of the packed lane bus.
    function automatic logic [DW-1:0] lane_slice(
        input logic [LANES*DW-1:0] bus,
        input logic [LANE_W-1:0]   lane
    );
        return bus[int'(lane) * DW +: DW];
    endfunction

endpackage

// File: rtl/maxpool_shadow_serializer.sv
// Shadow copy of the 16 lane maxima, streamed out one lane per beat.
// A load is only honoured while the shadow is empty.
module maxpool_shadow_serializer
    import maxpool_window_drain_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [LANES*DW-1:0]   i_bus,
    output logic                  o_full,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DW-1:0]         o_data,
    output logic [LANE_W-1:0]     o_lane,
    output logic                  o_last,
    output logic                  o_drain_end
);

    logic [LANES*DW-1:0] r_shadow;
    logic                r_full;
    logic [LANE_W-1:0]   r_lane;
    logic                w_fire;
    logic                w_at_last;

    assign w_fire    = r_full & i_ready;
    assign w_at_last = (r_lane == LAST_LANE);

    // Load on empty, otherwise step the lane pointer on each accepted beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow <= '0;
            r_full   <= 1'b0;
            r_lane   <= '0;
        end else if (i_load && !r_full) begin
            r_shadow <= i_bus;
            r_full   <= 1'b1;
        end else if (w_fire) begin
            if (w_at_last) begin
                r_full <= 1'b0;
                r_lane <= '0;
            end else begin
                r_lane <= r_lane + 1'b1;
            end
        end
    end

    assign o_full      = r_full;
    assign o_valid     = r_full;
    assign o_data      = lane_slice(r_shadow, r_lane);
    assign o_lane      = r_lane;
    assign o_last      = r_full & w_at_last;
    assign o_drain_end = w_fire & w_at_last;

endmodule

// File: rtl/maxpool_window_drain.sv
// Control for the 16-lane max-pool accumulators: strobe, count, capture.
// Captured maxima are drained lane by lane through the shadow serializer.
module maxpool_window_drain
    import maxpool_window_drain_pkg::*;
#(
    parameter int LEN_W = POOL_LEN_W,
    parameter int WIN_W = POOL_WIN_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [LEN_W-1:0]    i_pool_len,
    input  logic [WIN_W-1:0]    i_num_windows,
    input  logic                i_res_valid,
    output logic                o_res_ready,
    output logic                o_maxpool,
    output logic                o_max_rst,
    input  logic [LANES*DW-1:0] i_max_bus,
    output logic [DW-1:0]       o_data,
    output logic [LANE_W-1:0]   o_lane,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_last,
    output logic                o_busy,
    output logic                o_done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [WIN_W-1:0]  r_win_tot;
    logic [WIN_W-1:0]  r_win_cnt;
    logic              r_done;

    logic              w_full;
    logic              w_load;
    logic              w_drain_end;
    logic              w_hs;
    logic              w_start;
    logic              w_last_res;
    logic              w_last_win;

    assign w_hs       = i_res_valid & o_res_ready;
    assign w_start    = (r_state == ST_IDLE) & i_start
                      & (i_num_windows != '0);
    assign w_last_res = (r_cnt == r_len - 1'b1);
    assign w_last_win = (r_win_cnt + 1'b1 == r_win_tot);

    assign o_maxpool  = w_hs;
    assign o_busy     = (r_state != ST_IDLE) | w_full;
    assign o_done     = r_done;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control strobes.
    always_comb begin
        w_state_nxt = r_state;
        o_res_ready = 1'b0;
        o_max_rst   = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_max_rst   = 1'b1;
                w_state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                o_res_ready = 1'b1;
                if (i_res_valid && w_last_res) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!w_full) begin
                    w_load      = 1'b1;
                    o_max_rst   = 1'b1;
                    w_state_nxt = w_last_win ? ST_IDLE : ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Run parameters, result counter and window counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len     <= '0;
            r_cnt     <= '0;
            r_win_tot <= '0;
            r_win_cnt <= '0;
        end else begin
            if (w_start) begin
                r_len     <= (i_pool_len == '0) ? LEN_W'(1) : i_pool_len;
                r_win_tot <= i_num_windows;
                r_win_cnt <= '0;
                r_cnt     <= '0;
            end
            if (r_state == ST_CLEAR) begin
                r_cnt <= '0;
            end
            if (w_hs) begin
                r_cnt <= w_last_res ? '0 : r_cnt + 1'b1;
            end
            if (w_load) begin
                r_win_cnt <= r_win_cnt + 1'b1;
            end
        end
    end

    // Done follows the final drain beat only once the run has ended.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_drain_end & (r_state == ST_IDLE);
        end
    end

    maxpool_shadow_serializer u_ser (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_bus       (i_max_bus),
        .o_full      (w_full),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_lane      (o_lane),
        .o_last      (o_last),
        .o_drain_end (w_drain_end)
    );

endmodule

// File: tb/tb_maxpool_window_drain.sv
// Bench for maxpool_window_drain: lane maxima modelled per window,
// drain beats checked against a queue of expected lane values.
module tb_maxpool_window_drain;
    import maxpool_window_drain_pkg::*;

    typedef struct {
        logic [DW-1:0]     data;
        logic [LANE_W-1:0] lane;
        logic              last;
    } exp_t;

    logic                clk = 1'b0;
    logic                i_rst;
    logic                i_start;
    logic [3:0]          i_pool_len;
    logic [15:0]         i_num_windows;
    logic                i_res_valid;
    logic                o_res_ready;
    logic                o_maxpool;
    logic                o_max_rst;
    logic [LANES*DW-1:0] i_max_bus;
    logic [DW-1:0]       o_data;
    logic [LANE_W-1:0]   o_lane;
    logic                o_valid;
    logic                i_ready;
    logic                o_last;
    logic                o_busy;
    logic                o_done;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_pool, n_rst, n_done, n_out;
    int gap, last15;
    int eff_len, res_in_win, win_idx, vkind;
    bit prev_stall;
    logic [DW-1:0] prev_data;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    maxpool_window_drain dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_pool_len    (i_pool_len),
        .i_num_windows (i_num_windows),
        .i_res_valid   (i_res_valid),
        .o_res_ready   (o_res_ready),
        .o_maxpool     (o_maxpool),
        .o_max_rst     (o_max_rst),
        .i_max_bus     (i_max_bus),
        .o_data        (o_data),
        .o_lane        (o_lane),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    function automatic logic [DW-1:0] lane_val(int kind, int w, int k);
        if (kind == 0) return 32'(w * 1000 + k * 10);
        if ((k % 2) == 0) return 32'hFFFF_FFFF;
        return 32'h8000_0000;
    endfunction

    // One clock: sample at the falling edge, return just after the rising edge.
    task automatic step();
        exp_t e;
        logic [DW-1:0] v;
        @(negedge clk);
        cyc++;
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (o_valid !== 1'b1 || o_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold got v=%b d=%h want v=1 d=%h",
                             o_valid, o_data, prev_data);
                end
            end
            prev_stall = o_valid & ~i_ready;
            prev_data  = o_data;
            n_cmp++;
            if (o_maxpool && o_max_rst) begin
                n_fail++;
                $display("FAIL strobe_excl got maxpool=1 max_rst=1 want not both");
            end
            if (o_max_rst) n_rst++;
            if (o_done) n_done++;
            if (o_maxpool) begin
                n_pool++;
                res_in_win++;
                if (res_in_win == eff_len) begin
                    res_in_win = 0;
                    for (int k = 0; k < LANES; k++) begin
                        v = lane_val(vkind, win_idx, k);
                        i_max_bus[k*DW +: DW] = v;
                        e.data = v;
                        e.lane = LANE_W'(k);
                        e.last = (k == LANES - 1);
                        exp_q.push_back(e);
                    end
                    win_idx++;
                end
            end
            if (o_valid && i_ready) begin
                n_out++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL drain_extra got d=%h l=%0d want no beat",
                             o_data, o_lane);
                end else begin
                    e = exp_q.pop_front();
                    if (o_data !== e.data || o_lane !== e.lane
                        || o_last !== e.last) begin
                        n_fail++;
                        $display("FAIL drain got d=%h l=%0d last=%b want d=%h l=%0d last=%b",
                                 o_data, o_lane, o_last, e.data, e.lane, e.last);
                    end
                    if (e.lane == 0) gap = cyc - last15;
                    if (e.last) last15 = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_pool = 0;
        n_rst  = 0;
        n_done = 0;
        n_out  = 0;
        gap    = 0;
        last15 = 0;
    endtask

    task automatic start_run(input logic [3:0] len, input logic [15:0] nw);
        eff_len       = (len == 4'd0) ? 1 : int'(len);
        res_in_win    = 0;
        win_idx       = 0;
        i_pool_len    = len;
        i_num_windows = nw;
        i_start       = 1'b1;
        step();
        i_start       = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        for (int c = 0; c < budget && n_done == 0; c++) step();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({o_res_ready, o_maxpool, o_max_rst, o_valid,
             o_last, o_busy, o_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {o_res_ready, o_maxpool, o_max_rst, o_valid,
                      o_last, o_busy, o_done});
        end
        n_cmp++;
        if (o_data !== '0 || o_lane !== '0) begin
            n_fail++;
            $display("FAIL reset_data got d=%h l=%0d want 0 0", o_data, o_lane);
        end
        i_rst = 1'b0;
        step();
        n_cmp++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_res_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b valid=%b rdy=%b want 0 0 0",
                     o_busy, o_valid, o_res_ready);
        end
    endtask

    task automatic test_basic();
        vkind = 0;
        i_ready = 1'b1;
        i_res_valid = 1'b1;
        clear_counts();
        start_run(4'd4, 16'd1);
        n_cmp++;
        if (o_max_rst !== 1'b1 || o_res_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_clear got rst=%b rdy=%b want 1 0",
                     o_max_rst, o_res_ready);
        end
        run_until_done(200);
        n_cmp++;
        if (n_pool != 4 || n_rst != 2) begin
            n_fail++;
            $display("FAIL basic_strobes got pool=%0d rst=%0d want 4 2",
                     n_pool, n_rst);
        end
        n_cmp++;
        if (n_out != 16 || n_done != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_drain got out=%0d done=%0d left=%0d want 16 1 0",
                     n_out, n_done, exp_q.size());
        end
        repeat (3) step();
        n_cmp++;
        if (n_done != 1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after got done=%0d busy=%b want 1 0",
                     n_done, o_busy);
        end
    endtask

    task automatic test_backpressure();
        vkind = 0;
        i_ready = 1'b0;
        i_res_valid = 1'b1;
        clear_counts();
        start_run(4'd2, 16'd2);
        repeat (40) step();
        n_cmp++;
        if (o_res_ready !== 1'b0 || n_pool != 4 || n_rst != 2) begin
            n_fail++;
            $display("FAIL bp_stall got rdy=%b pool=%0d rst=%0d want 0 4 2",
                     o_res_ready, n_pool, n_rst);
        end
        n_cmp++;
        if (o_valid !== 1'b1 || o_lane !== 4'd0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold got v=%b l=%0d busy=%b want 1 0 1",
                     o_valid, o_lane, o_busy);
        end
        i_ready = 1'b1;
        run_until_done(400);
        n_cmp++;
        if (n_out != 32 || n_rst != 3 || n_done != 1) begin
            n_fail++;
            $display("FAIL bp_drain got out=%0d rst=%0d done=%0d want 32 3 1",
                     n_out, n_rst, n_done);
        end
        n_cmp++;
        if (gap != 2) begin
            n_fail++;
            $display("FAIL bp_bubble got gap=%0d want 2", gap);
        end
    endtask

    task automatic test_len0();
        vkind = 0;
        i_ready = 1'b1;
        i_res_valid = 1'b1;
        clear_counts();
        start_run(4'd0, 16'd3);
        run_until_done(600);
        n_cmp++;
        if (n_pool != 3 || n_rst != 4) begin
            n_fail++;
            $display("FAIL len0_strobes got pool=%0d rst=%0d want 3 4",
                     n_pool, n_rst);
        end
        n_cmp++;
        if (n_out != 48 || n_done != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL len0_drain got out=%0d done=%0d left=%0d want 48 1 0",
                     n_out, n_done, exp_q.size());
        end
    endtask

    task automatic test_negative();
        vkind = 1;
        i_ready = 1'b1;
        i_res_valid = 1'b1;
        clear_counts();
        start_run(4'd1, 16'd1);
        run_until_done(200);
        n_cmp++;
        if (n_out != 16 || n_done != 1) begin
            n_fail++;
            $display("FAIL neg_drain got out=%0d done=%0d want 16 1",
                     n_out, n_done);
        end
        vkind = 0;
    endtask

    task automatic test_reset_mid();
        vkind = 0;
        i_ready = 1'b1;
        i_res_valid = 1'b1;
        clear_counts();
        start_run(4'd3, 16'd2);
        for (int c = 0; c < 400 && n_out < 23; c++) step();
        i_ready = 1'b0;
        n_cmp++;
        if (o_valid !== 1'b1 || o_lane !== 4'd7) begin
            n_fail++;
            $display("FAIL rmid_pos got v=%b l=%0d want 1 7", o_valid, o_lane);
        end
        i_rst = 1'b1;
        step();
        n_cmp++;
        if ({o_res_ready, o_max_rst, o_valid, o_last, o_busy, o_done} !== 6'b0
            || o_data !== '0 || o_lane !== '0) begin
            n_fail++;
            $display("FAIL rmid_clear got ctl=%b d=%h l=%0d want 0 0 0",
                     {o_res_ready, o_max_rst, o_valid, o_last, o_busy, o_done},
                     o_data, o_lane);
        end
        i_rst = 1'b0;
        exp_q.delete();
        i_ready = 1'b1;
        clear_counts();
        start_run(4'd2, 16'd1);
        n_cmp++;
        if (o_max_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_restart got rst=%b want 1", o_max_rst);
        end
        run_until_done(200);
        n_cmp++;
        if (n_out != 16 || n_done != 1 || n_pool != 2) begin
            n_fail++;
            $display("FAIL rmid_run got out=%0d done=%0d pool=%0d want 16 1 2",
                     n_out, n_done, n_pool);
        end
    endtask

    task automatic test_start_ignored();
        vkind = 0;
        i_ready = 1'b1;
        i_res_valid = 1'b0;
        clear_counts();
        start_run(4'd4, 16'd2);
        repeat (3) step();
        n_rst = 0;
        i_pool_len = 4'd1;
        i_num_windows = 16'd5;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (n_rst != 0 || o_res_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start got rst=%0d rdy=%b want 0 1",
                     n_rst, o_res_ready);
        end
        i_res_valid = 1'b1;
        run_until_done(400);
        n_cmp++;
        if (n_pool != 8 || n_out != 32 || n_done != 1 || n_rst != 2) begin
            n_fail++;
            $display("FAIL busy_run got pool=%0d out=%0d done=%0d rst=%0d want 8 32 1 2",
                     n_pool, n_out, n_done, n_rst);
        end
        clear_counts();
        i_num_windows = 16'd0;
        i_pool_len = 4'd3;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (n_rst != 0 || n_pool != 0 || o_busy !== 1'b0
            || o_res_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_win got rst=%0d pool=%0d busy=%b rdy=%b want 0 0 0 0",
                     n_rst, n_pool, o_busy, o_res_ready);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_pool_len = '0;
        i_num_windows = '0;
        i_res_valid = 1'b0;
        i_ready = 1'b0;
        i_max_bus = '0;
        prev_stall = 1'b0;
        prev_data = '0;
        vkind = 0;
        eff_len = 1;
        res_in_win = 0;
        win_idx = 0;
        clear_counts();
        test_reset();
        test_basic();
        test_backpressure();
        test_len0();
        test_negative();
        test_reset_mid();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
